// File: rtl/ir_pkg.sv
// Shared NEC infrared definitions: transmitter state encoding and frame timing in NEC units.
// The receiver uses the same unit constants.
package ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK,
    ST_GAP
  } state_t;

  localparam int unsigned LEAD_MARK_U  = 16;
  localparam int unsigned LEAD_SPACE_U = 8;
  localparam int unsigned MARK_U       = 1;
  localparam int unsigned BIT0_SPACE_U = 1;
  localparam int unsigned BIT1_SPACE_U = 3;
  localparam int unsigned FRAME_BITS   = 32;

  function automatic logic is_mark(input state_t s);
    return s inside {ST_LEAD_MARK, ST_BIT_MARK, ST_STOP_MARK};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier phase counter with duty compare. carrier reflects the phase that will be held
// after the next edge, so a registered consumer lines up with the phase register.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_DIV = 316,
  parameter int unsigned CARRIER_HI  = 105
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic carrier
);

  localparam int unsigned PH_W = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_nxt;

  always_comb begin
    phase_nxt = '0;
    if (!clr && (phase != PH_W'(CARRIER_DIV - 1))) phase_nxt = phase + PH_W'(1);
  end

  assign carrier = (32'(phase_nxt) < CARRIER_HI);

  always_ff @(posedge clk) begin
    if (rst) phase <= '0;
    else     phase <= phase_nxt;
  end

endmodule

// File: rtl/ir_tx.sv
// NEC infrared transmitter: serialises a 32-bit word LSB first into leader, bits, stop mark
// and gap, driving a modulated LED output plus the raw envelope.
module ir_tx
  import ir_pkg::*;
#(
  parameter int unsigned UNIT_CYC    = 6750,
  parameter int unsigned CARRIER_DIV = 316,
  parameter int unsigned CARRIER_HI  = 105,
  parameter int unsigned GAP_UNITS   = 72
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        tx_env,
  output logic        tx_out
);

  localparam int unsigned CYC_W     = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int unsigned UNIT_MAX  = (GAP_UNITS > LEAD_MARK_U) ? GAP_UNITS : LEAD_MARK_U;
  localparam int unsigned UNIT_W    = $clog2(UNIT_MAX + 1);
  localparam state_t      FINAL_ST  = (GAP_UNITS == 0) ? ST_STOP_MARK : ST_GAP;
  localparam int unsigned FINAL_LEN = (GAP_UNITS == 0) ? MARK_U : GAP_UNITS;

  function automatic int unsigned state_len(input state_t s, input logic bit_val);
    case (s)
      ST_LEAD_MARK:  return LEAD_MARK_U;
      ST_LEAD_SPACE: return LEAD_SPACE_U;
      ST_BIT_SPACE:  return bit_val ? BIT1_SPACE_U : BIT0_SPACE_U;
      ST_GAP:        return GAP_UNITS;
      default:       return MARK_U;
    endcase
  endfunction

  state_t            state, state_nxt;
  logic [CYC_W-1:0]  cyc, cyc_nxt;
  logic [UNIT_W-1:0] unit, unit_nxt;
  logic [4:0]        idx, idx_nxt;
  logic [31:0]       shreg, shreg_nxt;
  logic              done_nxt;
  logic              unit_end;
  logic              state_end;
  logic              carrier_clr;
  logic              carrier;

  // Next-state, counters and shift register
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    unit_nxt  = unit;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    unit_end  = (cyc == CYC_W'(UNIT_CYC - 1));
    state_end = unit_end && (unit == UNIT_W'(state_len(state, shreg[0]) - 1));

    if (state == ST_IDLE) begin
      if (send) begin
        state_nxt = ST_LEAD_MARK;
        shreg_nxt = data;
        idx_nxt   = '0;
        cyc_nxt   = '0;
        unit_nxt  = '0;
      end
    end else begin
      if (unit_end) begin
        cyc_nxt  = '0;
        unit_nxt = unit + UNIT_W'(1);
      end else begin
        cyc_nxt  = cyc + CYC_W'(1);
      end
      if (state_end) begin
        unit_nxt = '0;
        case (state)
          ST_LEAD_MARK:  state_nxt = ST_LEAD_SPACE;
          ST_LEAD_SPACE: state_nxt = ST_BIT_MARK;
          ST_BIT_MARK:   state_nxt = ST_BIT_SPACE;
          ST_BIT_SPACE: begin
            shreg_nxt = shreg >> 1;
            if (idx == 5'(FRAME_BITS - 1)) begin
              state_nxt = ST_STOP_MARK;
            end else begin
              state_nxt = ST_BIT_MARK;
              idx_nxt   = idx + 5'd1;
            end
          end
          ST_STOP_MARK:  state_nxt = (GAP_UNITS == 0) ? ST_IDLE : ST_GAP;
          default:       state_nxt = ST_IDLE;
        endcase
      end
    end

    // done is registered, so raise it when the coming cycle is the final one of the frame
    done_nxt = (state_nxt == FINAL_ST) && (cyc_nxt == CYC_W'(UNIT_CYC - 1)) &&
               (unit_nxt == UNIT_W'(FINAL_LEN - 1));
  end

  assign carrier_clr = is_mark(state_nxt) && (state_nxt != state);

  ir_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV),
    .CARRIER_HI (CARRIER_HI)
  ) u_carrier (
    .clk    (clk),
    .rst    (rst),
    .clr    (carrier_clr),
    .carrier(carrier)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cyc    <= '0;
      unit   <= '0;
      idx    <= '0;
      shreg  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tx_env <= 1'b0;
      tx_out <= 1'b0;
    end else begin
      state  <= state_nxt;
      cyc    <= cyc_nxt;
      unit   <= unit_nxt;
      idx    <= idx_nxt;
      shreg  <= shreg_nxt;
      busy   <= (state_nxt != ST_IDLE);
      done   <= done_nxt;
      tx_env <= is_mark(state_nxt);
      tx_out <= is_mark(state_nxt) & carrier;
    end
  end

endmodule
